// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-first read bypass and a per-register
// busy scoreboard (set at alloc, cleared at writeback, wiped by flush).
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int NALLOC = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic [NALLOC-1:0]    alloc_en,
  input  logic [NALLOC*AW-1:0] alloc_addr,
  input  logic                 flush,
  output logic [NREG-1:0]      busy_vec
);

  logic [XLEN-1:0] mem_r [NREG];
  logic [NREG-1:0] busy_r;

  logic [NREG-1:0] wr_hit_s;
  logic [XLEN-1:0] wr_val_s [NREG];
  logic [NREG-1:0] alloc_hit_s;
  logic [NREG-1:0] busy_nxt_s;

  // Per-register write decode; scanning ports upward lets the highest index win.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wr_hit_s[r] = 1'b0;
      wr_val_s[r] = '0;
    end
    for (int r = 1; r < NREG; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
          wr_hit_s[r] = 1'b1;
          wr_val_s[r] = wr_data[p*XLEN +: XLEN];
        end else begin
          wr_hit_s[r] = wr_hit_s[r];
          wr_val_s[r] = wr_val_s[r];
        end
      end
    end
  end

  // Per-register alloc decode; several ports may target the same register.
  always_comb begin
    alloc_hit_s = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int a = 0; a < NALLOC; a++) begin
        if (alloc_en[a] && (alloc_addr[a*AW +: AW] == AW'(r))) begin
          alloc_hit_s[r] = 1'b1;
        end else begin
          alloc_hit_s[r] = alloc_hit_s[r];
        end
      end
    end
  end

  // Next busy state: a new producer supersedes a retiring one in the same cycle.
  always_comb begin
    busy_nxt_s = '0;
    for (int r = 1; r < NREG; r++) begin
      if (alloc_hit_s[r]) begin
        busy_nxt_s[r] = 1'b1;
      end else if (wr_hit_s[r]) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Data storage; register 0 is never written so it stays at its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        mem_r[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit_s[r]) begin
          mem_r[r] <= wr_val_s[r];
        end
      end
    end
  end

  // Busy scoreboard; flush clears every bit without touching data.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else if (flush) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy_vec = busy_r;

  // Read ports: write-first bypass; a same-cycle writeback masks the busy bit.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rst) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end else if (rd_addr[i*AW +: AW] == '0) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end else if (wr_hit_s[rd_addr[i*AW +: AW]]) begin
        rd_data[i*XLEN +: XLEN] = wr_val_s[rd_addr[i*AW +: AW]];
        rd_busy[i]              = 1'b0;
      end else begin
        rd_data[i*XLEN +: XLEN] = mem_r[rd_addr[i*AW +: AW]];
        rd_busy[i]              = busy_r[rd_addr[i*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: table of per-cycle vectors whose expected read results are
// queued at drive time and popped when the outputs are sampled on the falling edge.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [0:0]  alloc_en;
  logic [4:0]  alloc_addr;
  logic        flush;
  logic [31:0] busy_vec;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .flush(flush), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        ae;
    logic [4:0]  aa;
    logic        fl;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_d0, e_d1;
    logic        e_b0, e_b1;
    logic        chk_bv;
    logic [31:0] e_bv;
    string       name;
  } vec_t;

  vec_t vecs [$];
  vec_t exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(string name, logic r, logic [1:0] we,
                              logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1,
                              logic ae, logic [4:0] aa, logic fl,
                              logic [4:0] ra0, logic [31:0] e_d0, logic e_b0,
                              logic [4:0] ra1, logic [31:0] e_d1, logic e_b1,
                              logic chk_bv, logic [31:0] e_bv);
    vec_t v;
    v.name = name; v.rst = r; v.we = we;
    v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ae = ae; v.aa = aa; v.fl = fl;
    v.ra0 = ra0; v.e_d0 = e_d0; v.e_b0 = e_b0;
    v.ra1 = ra1; v.e_d1 = e_d1; v.e_b1 = e_b1;
    v.chk_bv = chk_bv; v.e_bv = e_bv;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Drive one cycle's inputs, check at the falling edge, then let the rising edge commit.
  task automatic step(vec_t v);
    vec_t e;
    rst        = v.rst;
    wr_en      = v.we;
    wr_addr    = {v.wa1, v.wa0};
    wr_data    = {v.wd1, v.wd0};
    alloc_en   = v.ae;
    alloc_addr = v.aa;
    flush      = v.fl;
    rd_addr    = {v.ra1, v.ra0};
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = exp_q.pop_front();
      chk({e.name, ".rd_data0"}, rd_data[31:0], e.e_d0);
      chk({e.name, ".rd_data1"}, rd_data[63:32], e.e_d1);
      chk({e.name, ".rd_busy0"}, {31'd0, rd_busy[0]}, {31'd0, e.e_b0});
      chk({e.name, ".rd_busy1"}, {31'd0, rd_busy[1]}, {31'd0, e.e_b1});
      if (e.chk_bv) chk({e.name, ".busy_vec"}, busy_vec, e.e_bv);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 2'b00; wr_addr = 10'd0; wr_data = 64'd0;
    alloc_en = 1'b0; alloc_addr = 5'd0; flush = 1'b0; rd_addr = 10'd0;

    // Reset: outputs forced to zero even with writes targeting the read address.
    vecs.push_back(mk("rst_hold", 1'b1, 2'b11, 5'd5, 32'h1234_5678, 5'd6, 32'h9, 1'b1, 5'd5, 1'b0,
                      5'd5, 32'h0, 1'b0, 5'd6, 32'h0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk("rst_second", 1'b1, 2'b01, 5'd5, 32'hCAFE, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1,
                      5'd5, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0));
    foreach (vecs[k]) step(vecs[k]);
    vecs.delete();

    // Hand sequence: sweep every address on both ports after reset.
    for (int a = 0; a < 32; a++) begin
      step(mk("reset_sweep", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
              5'(a), 32'h0, 1'b0, 5'(31 - a), 32'h0, 1'b0, 1'b1, 32'h0));
    end

    vecs.push_back(mk("bypass_x5", 1'b0, 2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                      5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("stored_x5", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                      5'd5, 32'hDEAD_BEEF, 1'b0, 5'd7, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("prio_x7", 1'b0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 1'b0,
                      5'd7, 32'h22, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("wr_x0", 1'b0, 2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                      5'd7, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("alloc_x3", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0,
                      5'd0, 32'h0, 1'b0, 5'd3, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("busy_x3", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                      5'd3, 32'h0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0000_0008));
    vecs.push_back(mk("wb_x3", 1'b0, 2'b10, 5'd0, 32'h0, 5'd3, 32'h44, 1'b0, 5'd0, 1'b0,
                      5'd3, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0000_0008));
    vecs.push_back(mk("alloc_wr_x9", 1'b0, 2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0,
                      5'd3, 32'h44, 1'b0, 5'd9, 32'h55, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("busy_x9", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0,
                      5'd5, 32'hDEAD_BEEF, 1'b0, 5'd9, 32'h55, 1'b1, 1'b1, 32'h0000_0200));
    vecs.push_back(mk("alloc_x2", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0,
                      5'd1, 32'h0, 1'b1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h0000_0202));
    vecs.push_back(mk("alloc_x4", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0,
                      5'd2, 32'h0, 1'b1, 5'd4, 32'h0, 1'b0, 1'b1, 32'h0000_0206));
    vecs.push_back(mk("flush", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1,
                      5'd4, 32'h0, 1'b1, 5'd9, 32'h55, 1'b1, 1'b1, 32'h0000_0216));
    vecs.push_back(mk("flush_vs_alloc", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1,
                      5'd7, 32'h22, 1'b0, 5'd3, 32'h44, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk("post_flush", 1'b0, 2'b01, 5'd11, 32'hABCD, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0,
                      5'd6, 32'h0, 1'b0, 5'd9, 32'h55, 1'b0, 1'b1, 32'h0));
    foreach (vecs[k]) step(vecs[k]);
    vecs.delete();

    // Hand sequence: reset lands mid-stream with a write and alloc pending.
    step(mk("pre_rst", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
            5'd11, 32'hABCD, 1'b0, 5'd10, 32'h0, 1'b1, 1'b1, 32'h0000_0400));
    step(mk("mid_rst", 1'b1, 2'b10, 5'd0, 32'h0, 5'd12, 32'h77, 1'b1, 5'd12, 1'b0,
            5'd12, 32'h0, 1'b0, 5'd10, 32'h0, 1'b0, 1'b1, 32'h0000_0400));
    step(mk("after_rst_a", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
            5'd12, 32'h0, 1'b0, 5'd11, 32'h0, 1'b0, 1'b1, 32'h0));
    step(mk("after_rst_b", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
            5'd5, 32'h0, 1'b0, 5'd7, 32'h0, 1'b0, 1'b1, 32'h0));

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with per-register busy scoreboard. It serves as the architectural register store for a wider-issue pipeline. It provides NRD combinational read ports with same-cycle write-through bypass and NWR write ports with fixed priority. Busy bits are set at issue (alloc) and cleared at writeback, so decode can stall on pending producers. A flush clears all busy bits without touching data.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of registers (power of two, ≥2); AW = $clog2(NREG)
- NRD, 2, number of read ports (≥1)
- NWR, 2, number of write ports (≥1)
- NALLOC, 1, number of alloc (busy-set) ports (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, combinational
- rd_busy  out  NRD  1 = register has an outstanding producer, combinational
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- alloc_en  in  NALLOC  mark register busy
- alloc_addr  in  NALLOC*AW  register to mark busy
- flush  in  1  clear all busy bits
- busy_vec  out  NREG  registered busy bits, bit r = register r

## Operation
- Register 0 is hardwired: reads return 0 and busy 0; writes and allocs to address 0 are ignored.
- Write priority: if several write ports target the same address in one cycle, the highest-index port wins. Both storage and bypass use the same winner.
- Read bypass (write-first): if any enabled write hits rd_addr[i] (≠0) this cycle, rd_data[i] equals the winning wr_data. Otherwise it is the stored value.
- Busy update per edge, per register r≠0, in priority order:
  - flush → 0;
  - else any alloc hits r → 1;
  - else any write hits r → 0;
  - else hold.
- Alloc beats write in the same cycle: a new producer supersedes the retiring one, and the data write still commits.
- rd_busy[i] = busy[addr] & ~(any enabled write hits addr this cycle). Same-cycle allocs and flush do not affect rd_busy. Address 0 always gives 0.
- Multiple allocs to the same register in one cycle are legal; the result is busy = 1.
- Reset: all data = 0 and all busy = 0 at the first edge with rst=1.
- While rst=1, rd_data = 0 and rd_busy = 0 regardless of inputs. Writes, allocs and flush are ignored while rst=1.
- Reset asserted mid-operation discards all pending state with no partial commit.

## Timing
- Write → storage: 1 cycle. Write → read of the same address: 0 cycles via bypass.
- Alloc → busy_vec/rd_busy visible: next cycle.
- Write → busy clear: rd_busy drops the same cycle via the mask; busy_vec drops the next cycle.
- flush → busy_vec all-zero the next cycle.
- Reset values: busy_vec = 0. rd_data and rd_busy are 0 while rst is high and follow the rules above afterward.
- No handshakes: all ports are single-cycle, fire-and-forget.
- Combinational path: rd_addr/wr_* → rd_data/rd_busy. No comb path from alloc_en or flush to any output.

## Test plan
- Reset, then read all addresses → rd_data = 0, rd_busy = 0, busy_vec = 0.
- Cycle 1: wr port0 x5 = 0xDEADBEEF and read x5 same cycle → rd_data = 0xDEADBEEF (bypass). Cycle 2: read x5 with no write → 0xDEADBEEF.
- Same cycle: port0 writes x7 = 0x11 and port1 writes x7 = 0x22 → bypass and stored value = 0x22. Write x0 = 0xFFFFFFFF → read x0 = 0.
- Alloc x3 → next cycle rd_busy = 1, busy_vec[3] = 1. Then write x3 = 0x44 → rd_busy = 0 that cycle and busy_vec[3] = 0 the next.
- Same cycle: alloc x9 and write x9 = 0x55 → next cycle busy_vec[9] = 1 and read x9 = 0x55.
- Alloc x1, x2, x4; then flush → busy_vec = 0 next cycle with data intact. Assert rst mid-stream with a write pending → data and busy all 0 afterward.
